// File: rtl/sba_ctrl.sv
// System-bus access front end: sbcs/sbaddress0/sbdata0 registers driving single APB-style transfers.
// Latency: trigger on cycle T, start_o at T+1, then waits for ready_i; register read mux is combinational.
// Backpressure: the downstream controller stalls via ready_i; DMI accesses while busy set sbbusyerror and are dropped.

package sba_pkg;
    typedef enum logic [2:0] {
        SIZE_B = 3'd0,
        SIZE_H = 3'd1,
        SIZE_W = 3'd2
    } cs_size;
endpackage

module sba_ctrl
    import sba_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wr_i,
    input  logic              reg_rd_i,
    input  logic [6:0]        reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    output logic [31:0]       reg_rdata_o,
    output logic              start_o,
    output logic              dir_o,
    output cs_size            size_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DAT_W-1:0]  wdata_o,
    input  logic              ready_i,
    input  logic              valid_i,
    input  logic              err_i,
    input  logic [DAT_W-1:0]  rdata_i
);

    localparam logic [6:0] A_SBCS   = 7'h38;
    localparam logic [6:0] A_SBADDR = 7'h39;
    localparam logic [6:0] A_SBDATA = 7'h3C;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state_q, state_d;

    // sbcs fields
    logic        busyerr_q;
    logic        roa_q;
    logic [2:0]  access_q;
    logic        autoinc_q;
    logic        rod_q;
    logic [2:0]  sberror_q;

    // data-path registers
    logic [ADDR_W-1:0] sbaddr_q;
    logic [DAT_W-1:0]  sbdata_q;

    // transfer attributes captured when the request is accepted
    logic              xdir_q;
    cs_size            xsize_q;
    logic [ADDR_W-1:0] xaddr_q;

    logic              busy;
    logic              wr_sbcs, wr_addr, wr_data, rd_data;
    logic              busy_viol;
    logic              trig_req, trig_dir, trig_go;
    logic [ADDR_W-1:0] trig_addr;
    logic              size_bad, misalign;
    logic              done;
    logic [ADDR_W-1:0] incr;
    logic [DAT_W-1:0]  rdata_masked;

    assign busy      = (state_q != IDLE);
    assign wr_sbcs   = reg_wr_i && (reg_addr_i == A_SBCS);
    assign wr_addr   = reg_wr_i && (reg_addr_i == A_SBADDR);
    assign wr_data   = reg_wr_i && (reg_addr_i == A_SBDATA);
    assign rd_data   = reg_rd_i && (reg_addr_i == A_SBDATA);
    assign busy_viol = busy && (wr_addr || wr_data || rd_data);
    assign done      = (state_q == WAIT) && ready_i;

    // Decode a transfer trigger; any sticky error blocks new transfers
    always_comb begin
        trig_req  = 1'b0;
        trig_dir  = 1'b0;
        trig_addr = sbaddr_q;
        if (!busy && (sberror_q == 3'd0) && !busyerr_q) begin
            if (wr_addr && roa_q) begin
                trig_req  = 1'b1;
                trig_addr = reg_wdata_i[ADDR_W-1:0];
            end else if (wr_data) begin
                trig_req = 1'b1;
                trig_dir = 1'b1;
            end else if (rd_data && rod_q) begin
                trig_req = 1'b1;
            end
        end
    end

    // Pre-checks on the requested access size and alignment
    always_comb begin
        size_bad = (access_q > 3'd2);
        misalign = ((access_q == 3'd1) && trig_addr[0]) ||
                   ((access_q == 3'd2) && (trig_addr[1:0] != 2'b00));
        trig_go  = trig_req && !size_bad && !misalign;
    end

    // Next-state logic for the transfer sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig_go) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Autoincrement step and read-data lane selection follow the latched size
    always_comb begin
        incr         = ADDR_W'(4);
        rdata_masked = rdata_i;
        case (xsize_q)
            SIZE_B: begin
                incr         = ADDR_W'(1);
                rdata_masked = DAT_W'(rdata_i[7:0]);
            end
            SIZE_H: begin
                incr         = ADDR_W'(2);
                rdata_masked = DAT_W'(rdata_i[15:0]);
            end
            default: begin
                incr         = ADDR_W'(4);
                rdata_masked = rdata_i;
            end
        endcase
    end

    // sbcs fields: config always writable, W1C errors, error capture (bus error wins over W1C)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyerr_q <= 1'b0;
            roa_q     <= 1'b0;
            access_q  <= 3'd2;
            autoinc_q <= 1'b0;
            rod_q     <= 1'b0;
            sberror_q <= 3'd0;
        end else begin
            if (wr_sbcs) begin
                roa_q     <= reg_wdata_i[20];
                access_q  <= reg_wdata_i[19:17];
                autoinc_q <= reg_wdata_i[16];
                rod_q     <= reg_wdata_i[15];
                if (reg_wdata_i[22]) busyerr_q <= 1'b0;
                sberror_q <= sberror_q & ~reg_wdata_i[14:12];
            end
            if (busy_viol) busyerr_q <= 1'b1;
            if (trig_req && size_bad)      sberror_q <= 3'd4;
            else if (trig_req && misalign) sberror_q <= 3'd3;
            if (done && err_i) sberror_q <= 3'd7;
        end
    end

    // sbaddress0 / sbdata0: DMI writes when idle, completion updates when a transfer ends cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbaddr_q <= '0;
            sbdata_q <= '0;
        end else begin
            if (!busy && wr_addr) sbaddr_q <= reg_wdata_i[ADDR_W-1:0];
            if (!busy && wr_data) sbdata_q <= reg_wdata_i[DAT_W-1:0];
            if (done && !err_i) begin
                if (!xdir_q && valid_i) sbdata_q <= rdata_masked;
                if (autoinc_q)          sbaddr_q <= sbaddr_q + incr;
            end
        end
    end

    // Latch transfer attributes so later sbcs edits cannot disturb an in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xdir_q  <= 1'b0;
            xsize_q <= SIZE_W;
            xaddr_q <= '0;
        end else if ((state_q == IDLE) && trig_go) begin
            xdir_q  <= trig_dir;
            xsize_q <= cs_size'(access_q);
            xaddr_q <= trig_addr;
        end
    end

    assign start_o = (state_q == ISSUE);
    assign dir_o   = xdir_q;
    assign size_o  = xsize_q;
    assign addr_o  = xaddr_q;
    assign wdata_o = sbdata_q;

    // DMI read mux; unmapped addresses return zero
    always_comb begin
        reg_rdata_o = '0;
        case (reg_addr_i)
            A_SBCS: reg_rdata_o = {3'd1, 6'd0, busyerr_q, busy, roa_q, access_q,
                                   autoinc_q, rod_q, sberror_q, 7'(ADDR_W), 2'b00, 3'b111};
            A_SBADDR: reg_rdata_o[ADDR_W-1:0] = sbaddr_q;
            A_SBDATA: reg_rdata_o = sbdata_q;
            default:  reg_rdata_o = '0;
        endcase
    end

endmodule
